// File: rtl/aes_key_expand.sv
// AES-128 key schedule: streams round keys 0..10 one per clock and keeps them in an indexed register file.
// Optional AES_KEY_CACHE_EN: skips re-expansion when the last fully expanded key is loaded again.
module aes_key_expand #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_ld,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_idx,
    output logic         rk_vld,
    output logic         busy,
    output logic         done,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key
);

    localparam logic [3:0] LAST = 4'(NR);

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EXPAND
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [127:0]   key_store [0:10];
    logic [127:0]   next_rk;
    logic           key_accept;
    logic           cache_hit;
    logic           start;

    // Byte b sits (255-b) bytes above the bottom of the packed table, i.e. at bit offset {~b,3'b0}.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // One key-schedule round applied to the key currently on rk_out, producing round rk_idx+1.
    always_comb begin
        logic [31:0] w0, w1, w2, w3, rot, t, n0, n1, n2, n3;
        w0  = rk_out[127:96];
        w1  = rk_out[95:64];
        w2  = rk_out[63:32];
        w3  = rk_out[31:0];
        rot = {w3[23:0], w3[31:24]};
        t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
              ^ {rcon(rk_idx + 4'd1), 24'h000000};
        n0  = w0 ^ t;
        n1  = w1 ^ n0;
        n2  = w2 ^ n1;
        n3  = w3 ^ n2;
        next_rk = {n0, n1, n2, n3};
    end

`ifdef AES_KEY_CACHE_EN
    logic [127:0] cache_key;
    logic         cache_vld;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cache_key <= '0;
            cache_vld <= 1'b0;
        end else if (state_q == EXPAND && rk_idx == LAST) begin
            cache_key <= key_store[0];
            cache_vld <= 1'b1;
        end
    end

    assign cache_hit = cache_vld && (key_in == cache_key);
`else
    assign cache_hit = 1'b0;
`endif

    assign key_accept = (state_q == IDLE) && key_ld;
    assign start      = key_accept && !cache_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    state_d = EXPAND;
            EXPAND:  if (rk_idx == LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // rk_idx doubles as the round counter; each new round key is written to the store as it is streamed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rk_out <= '0;
            rk_idx <= '0;
            rk_vld <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            for (int i = 0; i <= 10; i++) begin
                key_store[i] <= '0;
            end
        end else begin
            done <= (state_q == EXPAND && rk_idx == LAST - 4'd1) || (key_accept && cache_hit);
            case (state_q)
                IDLE: begin
                    if (start) begin
                        rk_out       <= key_in;
                        rk_idx       <= '0;
                        rk_vld       <= 1'b1;
                        busy         <= 1'b1;
                        key_store[0] <= key_in;
                    end
                end
                LOAD, EXPAND: begin
                    if (rk_idx != LAST) begin
                        rk_out                     <= next_rk;
                        rk_idx                     <= rk_idx + 4'd1;
                        key_store[rk_idx + 4'd1]   <= next_rk;
                    end else begin
                        rk_vld <= 1'b0;
                        busy   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_key = '0;
        if (rd_idx <= LAST) begin
            rd_key = key_store[rd_idx];
        end
    end

endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
- Upstream key-schedule stage for the AES core.
- Takes a 128-bit cipher key and generates the 11 AES-128 round keys, one per clock, over 11 cycles.
- Streams each round key out and also stores it in an internal 11-entry register file, so the round datapath can fetch any round key by index.
- Contains 4 internal S-box lookups for SubWord, the RotWord/Rcon logic, and a small control FSM.

Parameters:
- NR, 10, number of rounds; fixed at 10 for AES-128; other values are unsupported.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-low reset
- key_in  in  128  cipher key; byte 0 = bits [127:120]; sampled on the cycle key_ld is accepted
- key_ld  in  1  start request; accepted only when busy=0
- rk_out  out  128  streamed round key
- rk_idx  out  4  round number of rk_out, 0..10
- rk_vld  out  1  rk_out/rk_idx valid this cycle
- busy  out  1  expansion in progress
- done  out  1  one-cycle pulse when round key 10 is valid
- rd_idx  in  4  read address into the stored round keys
- rd_key  out  128  stored round key rd_idx; combinational read; 0 for rd_idx>10

Behaviour:
- Reset (rst=0, asynchronous):
  - rk_out=0, rk_idx=0, rk_vld=0, busy=0, done=0.
  - FSM returns to IDLE, round counter=0, all 11 stored keys cleared to 0.
  - A reset mid-expansion aborts immediately; no partial key stream continues after release.
- FSM states:
  - IDLE: key_ld=1 → LOAD.
  - LOAD: one cycle → EXPAND.
  - EXPAND: stays while counter<10; at counter==10 → IDLE.
- Timing when key_ld=1 is accepted in cycle N:
  - Cycle N+1: rk_out=key_in (as captured at N), rk_idx=0, rk_vld=1, busy=1; stored key[0] written.
  - Cycles N+2..N+11: rk_idx=1..10, one new round key per cycle, rk_vld=1; stored key[i] written in the same cycle its value appears on rk_out.
  - Cycle N+11: done=1 together with rk_idx=10.
  - Cycle N+12: busy=0, rk_vld=0, rk_out holds round key 10, and a new key_ld is accepted.
  - Back-to-back: key_ld held high through N+11 starts a new expansion at N+12, with rk_idx=0 at N+13.
- key_ld while busy=1 is ignored; key_in changes during expansion have no effect.
- Round computation, word-wise, with w0..w3 = previous round key (w0 = bits [127:96]):
  - t = SubWord(RotWord(w3)) XOR {Rcon[i],24'h0}
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
- rd_key reads are valid at any time.
  - A stored entry is overwritten only when that round is regenerated.
  - During a new expansion, entries whose index is above the current rk_idx still hold the previous key's values.

Optional Feature:
- Macro: AES_KEY_CACHE_EN.
- Defined:
  - The block keeps a copy of the last fully expanded key and a cache-valid flag.
  - The flag is cleared by reset and set at done.
  - If key_ld is accepted with cache-valid=1 and key_in equal to the cached key: FSM skips expansion; done pulses at N+1; busy and rk_vld stay 0; rd_key contents are unchanged.
  - Any other key expands normally.
- Not defined:
  - Every accepted key_ld performs the full 11-cycle expansion.

Test Plan:
- Reset, then key_ld with key_in=2b7e151628aed2a6abf7158809cf4f3c:
  - N+1: rk_idx=0, rk_out=2b7e1516...4f3c.
  - N+2: rk_out=a0fafe1788542cb123a339392a6c7605.
  - N+11: rk_out=d014f9a8c9ee2589e13f0cc8b6630ca6 with done=1.
  - N+12: busy=0.
- key_in=0:
  - rk_idx=1 gives 62636363626363636263636362636363.
  - rk_idx=10 gives b4ef5bcb3e92e21123e951cf6f8f188e.
  - After done, rd_idx=1 and rd_idx=10 return the same two values; rd_idx=11..15 return 0.
- key_ld pulsed at rk_idx=4 with a different key_in:
  - Ignored; the stream completes with the original key's values.
  - Exactly one done pulse.
- rst driven low at rk_idx=5:
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - After release with no key_ld, rk_vld stays 0; rd_key=0 for all indices.
- key_ld held high continuously for two expansions (FIPS key, then zero key):
  - Second rk_idx=0 appears at N+13.
  - Second done appears at N+23.
- With AES_KEY_CACHE_EN:
  - Re-load the FIPS key after its expansion: done=1 at N+1, rk_vld never asserted, rd_idx=10 still returns d014f9a8...0ca6.
  - Load a different key: full 11-cycle expansion.
